// File: rtl/frame_pack_bpsk_if.sv
// frame_pack_bpsk_if: byte-stream input and slicer word handshake for frame_pack_bpsk.
// The master side is the byte source plus slicer.
// The slave side is the packer.
interface frame_pack_bpsk_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output in_valid, in_data, in_last, ack_o,
    input  in_ready, valid_o, data_o
  );

  modport slave (
    input  in_valid, in_data, in_last, ack_o,
    output in_ready, valid_o, data_o
  );
endinterface

// File: rtl/frame_pack_bpsk.sv
// frame_pack_bpsk: packs a byte stream into framed 32-bit words for the BPSK slicer.
// Each frame is a sync word, then the payload (little-endian, zero-padded),
// then a trailer of {TRL_TAG, seq, byte_cnt, cksum}.
// Optional feature macro FRAME_CKSUM_EN: when defined, cksum is the XOR of the
// payload bytes. Otherwise trailer bits [7:0] are 8'h00.
module frame_pack_bpsk #(
  parameter logic [31:0] SYNC_WORD = 32'hD391_7E5A,
  parameter logic [7:0]  TRL_TAG   = 8'h5A
) (
  input logic              CLK,
  input logic              RST,
  frame_pack_bpsk_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_PAY  = 3'b010;
  localparam logic [2:0] S_TRL  = 3'b100;

  logic [2:0]  state;
  logic [31:0] asm_q;
  logic [1:0]  k;
  logic        asm_full;
  logic        asm_last;
  logic [7:0]  seq;
  logic [7:0]  byte_cnt;
  logic [7:0]  cksum;
  logic        valid_q;
  logic [31:0] data_q;

  logic out_free;
  logic accept;
  logic closes_frame;
  logic trl_load;

  // The output register may take a new word when empty or when the slicer is
  // capturing the current one. in_ready uses the pre-transfer asm_full, so a
  // full assembly word is never overwritten by an incoming byte.
  assign out_free     = !valid_q || bus.ack_o;
  assign bus.in_ready = (state == S_PAY) && !asm_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign closes_frame = bus.in_last || (byte_cnt == 8'd254);
  assign trl_load     = (state == S_TRL) && out_free;
  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;

  // Frame sequencing, byte assembly and the output word register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      asm_q    <= 32'h0;
      k        <= 2'd0;
      asm_full <= 1'b0;
      asm_last <= 1'b0;
      seq      <= 8'h00;
      byte_cnt <= 8'h00;
      valid_q  <= 1'b0;
      data_q   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && out_free) begin
            data_q  <= SYNC_WORD;
            valid_q <= 1'b1;
            state   <= S_PAY;
          end else if (bus.ack_o) begin
            valid_q <= 1'b0;
          end
        end
        S_PAY: begin
          if (asm_full && out_free) begin
            data_q   <= asm_q;
            valid_q  <= 1'b1;
            asm_q    <= 32'h0;
            k        <= 2'd0;
            asm_full <= 1'b0;
            asm_last <= 1'b0;
            if (asm_last) begin
              state <= S_TRL;
            end
          end else begin
            if (bus.ack_o) begin
              valid_q <= 1'b0;
            end
            if (accept) begin
              asm_q[{k, 3'b000} +: 8] <= bus.in_data;
              byte_cnt                <= byte_cnt + 8'd1;
              k                       <= k + 2'd1;
              if ((k == 2'd3) || closes_frame) begin
                asm_full <= 1'b1;
              end
              if (closes_frame) begin
                asm_last <= 1'b1;
              end
            end
          end
        end
        S_TRL: begin
          if (out_free) begin
            data_q   <= {TRL_TAG, seq, byte_cnt, cksum};
            valid_q  <= 1'b1;
            seq      <= seq + 8'd1;
            byte_cnt <= 8'h00;
            state    <= S_IDLE;
          end else if (bus.ack_o) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_CKSUM_EN
  // Running XOR of the frame's payload bytes, cleared as the trailer is loaded.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cksum <= 8'h00;
    end else if (trl_load) begin
      cksum <= 8'h00;
    end else if (accept) begin
      cksum <= cksum ^ bus.in_data;
    end
  end
`else
  assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_frame_pack_bpsk.sv
// tb_frame_pack_bpsk: directed test of frame_pack_bpsk.
// The checksum expectations follow FRAME_CKSUM_EN.
module tb_frame_pack_bpsk;

  localparam logic [31:0] SYNC = 32'hD391_7E5A;
`ifdef FRAME_CKSUM_EN
  localparam logic [7:0] CK_MASK = 8'hFF;
`else
  localparam logic [7:0] CK_MASK = 8'h00;
`endif

  logic CLK = 1'b0;
  logic RST;

  frame_pack_bpsk_if bus ();

  frame_pack_bpsk dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  pay_q[$];

  function automatic logic [7:0] ck(input logic [7:0] x);
    return x & CK_MASK;
  endfunction

  task automatic checkOutput(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the packer accepts it.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({31'b0, bus.in_ready}, 32'd1, "byte_accept");
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // mode 0: no in_last, 1: in_last on final byte, 2: in_last on every byte.
  task automatic sendPayload(input int mode);
    for (int i = 0; i < pay_q.size(); i++) begin
      applyStimulus(pay_q[i], (mode == 2) || (mode == 1 && i == pay_q.size() - 1));
    end
  endtask

  // Act as the slicer: check each expected word, optionally stall the first one.
  task automatic expectWords(input int hold);
    int n;
    @(negedge CLK);
    for (int i = 0; i < exp_q.size(); i++) begin
      n = 0;
      while (!bus.valid_o && n < 300) begin
        @(negedge CLK);
        n++;
      end
      checkOutput({31'b0, bus.valid_o}, 32'd1, "word_valid");
      checkOutput(bus.data_o, exp_q[i], "word_data");
      if (i == 0 && hold > 0) begin
        repeat (hold) @(negedge CLK);
        checkOutput({31'b0, bus.valid_o}, 32'd1, "hold_valid");
        checkOutput(bus.data_o, exp_q[0], "hold_data");
        checkOutput({31'b0, bus.in_ready}, 32'd0, "hold_in_ready");
      end
      bus.ack_o = 1'b1;
      @(negedge CLK);
      bus.ack_o = 1'b0;
    end
  endtask

  initial begin
    RST          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.ack_o    = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput({31'b0, bus.valid_o}, 32'd0, "rst_valid");
    checkOutput({31'b0, bus.in_ready}, 32'd0, "rst_in_ready");
    checkOutput(bus.data_o, 32'h0, "rst_data");
    RST = 1'b1;

    // Full words, seq 0
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_q = '{SYNC, 32'h0403_0201, 32'h0807_0605, {8'h5A, 8'h00, 8'h08, ck(8'h08)}};
    fork
      sendPayload(1);
      expectWords(0);
    join

    // Partial word, seq 1
    pay_q = '{8'hAB};
    exp_q = '{SYNC, 32'h0000_00AB, {8'h5A, 8'h01, 8'h01, ck(8'hAB)}};
    fork
      sendPayload(1);
      expectWords(0);
    join

    // Backpressure on the sync word, seq 2
    pay_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    exp_q = '{SYNC, 32'h1413_1211, 32'h1817_1615, {8'h5A, 8'h02, 8'h08, ck(8'h08)}};
    fork
      sendPayload(1);
      expectWords(40);
    join

    // Length cap: 255 bytes 00..FE without in_last, then a 256th byte EE
    pay_q.delete();
    exp_q.delete();
    for (int i = 0; i < 255; i++) pay_q.push_back(i[7:0]);
    exp_q.push_back(SYNC);
    for (int w = 0; w < 64; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        int idx;
        idx = 4 * w + b;
        if (idx < 255) word[8*b +: 8] = idx[7:0];
      end
      exp_q.push_back(word);
    end
    exp_q.push_back({8'h5A, 8'h03, 8'hFF, ck(8'hFF)});
    exp_q.push_back(SYNC);
    exp_q.push_back(32'h0000_00EE);
    exp_q.push_back({8'h5A, 8'h04, 8'h01, ck(8'hEE)});
    fork
      begin
        sendPayload(0);
        applyStimulus(8'hEE, 1'b1);
      end
      expectWords(0);
    join

    // Reset mid-payload
    pay_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_q = '{SYNC};
    fork
      sendPayload(0);
      expectWords(0);
    join
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput({31'b0, bus.valid_o}, 32'd0, "midrst_valid");
    checkOutput({31'b0, bus.in_ready}, 32'd0, "midrst_in_ready");
    checkOutput(bus.data_o, 32'h0, "midrst_data");
    @(negedge CLK);
    RST = 1'b1;
    pay_q = '{8'h5A};
    exp_q = '{SYNC, 32'h0000_005A, {8'h5A, 8'h00, 8'h01, ck(8'h5A)}};
    fork
      sendPayload(1);
      expectWords(0);
    join

    // Sequence wrap: 256 one-byte frames, seq 01..FF then 00
    pay_q.delete();
    exp_q.delete();
    for (int f = 0; f < 256; f++) begin
      logic [7:0] s;
      s = 8'(f + 1);
      pay_q.push_back(f[7:0]);
      exp_q.push_back(SYNC);
      exp_q.push_back({24'h0, f[7:0]});
      exp_q.push_back({8'h5A, s, 8'h01, ck(f[7:0])});
    end
    fork
      sendPayload(2);
      expectWords(0);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
